bcm_plane_scheduler: RTL and testbench
======================================

Name: bcm_plane_scheduler

Overview:
- Sequences binary-coded-modulation display of the LED matrix, one row and one bit-plane at a time.
- Requests the row shifter to load the next plane and issues `row_latch`.
- Drives the active brightness mask and row address consumed by the brightness timeout/output-enable stage.
- Overlaps shifting of plane N+1 with the on-time of plane N; latches only once the shifter is done and `output_enable` has fallen.

Parameters:
- BRIGHTNESS_LEVELS, params_pkg::BRIGHTNESS_LEVELS: number of bit-planes; width of the one-hot masks.
- ROWS, 16: number of multiplexed row addresses, ≥2.
- SHIFT_WATCHDOG, 4096: cycle limit for shift completion; used only with the optional feature.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request; scanning proceeds while high.
- shift_done  input  1  one-cycle pulse from the shifter: requested plane is fully shifted.
- output_enable  input  1  high while the current plane's on-time is running.
- shift_start  output  1  one-cycle pulse requesting a shift of the plane in brightness_mask for row_address.
- brightness_mask  output  BRIGHTNESS_LEVELS  one-hot plane being shifted.
- row_address  output  $clog2(ROWS)  row being shifted.
- brightness_mask_active  output  BRIGHTNESS_LEVELS  one-hot plane currently displayed.
- row_address_active  output  $clog2(ROWS)  row currently displayed.
- row_latch  output  1  one-cycle latch strobe; the on-time starts as it falls.
- frame_start  output  1  one-cycle pulse at the latch of row 0, plane 0.
- shift_fault  output  1  sticky watchdog fault; tied 0 without the optional feature.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; brightness_mask=1 (plane 0); brightness_mask_active=0; row_address=0; row_address_active=0.
  - shift_start, row_latch, frame_start, shift_fault all 0.
- Registered outputs; states:
  - IDLE:
    - enable=1 → SHIFT next cycle.
    - enable=0 → stay; brightness_mask_active forced to 0, which the timeout stage treats as non-one-hot (1-cycle minimum).
  - SHIFT: shift_start=1 for exactly this cycle → WAIT_SHIFT.
  - WAIT_SHIFT: on shift_done → WAIT_OE.
    - A shift_done arriving in the SHIFT cycle itself is ignored; the shifter never responds same-cycle.
  - WAIT_OE: when output_enable=0 → LATCH. If output_enable is already 0 on entry, LATCH follows next cycle.
  - LATCH, for one cycle:
    - row_latch=1; brightness_mask_active<=brightness_mask; row_address_active<=row_address.
    - frame_start=1 iff brightness_mask==1 and row_address==0.
    - → ADVANCE.
  - ADVANCE:
    - Rotate brightness_mask left by one.
    - On wrap from bit BRIGHTNESS_LEVELS-1 to bit 0, row_address increments.
    - row_address wraps ROWS-1 → 0.
    - Then enable=1 → SHIFT; enable=0 → IDLE.
- Masks: brightness_mask is always exactly one-hot. brightness_mask_active is one-hot or zero.
- Loop timing: LATCH→ADVANCE→SHIFT→WAIT_SHIFT→WAIT_OE is ≥3 cycles after row_latch falls. The stale output_enable=0 present just after the latch is therefore never sampled.
- Minimum latch period:
  - 5 cycles (SHIFT, WAIT_SHIFT, WAIT_OE, LATCH, ADVANCE) when shift_done comes 1 cycle after shift_start and output_enable is already low.
  - Otherwise the period is the max of shift time and on-time, plus the fixed states.
- enable deasserted mid-plane: the current plane completes through LATCH and ADVANCE, then IDLE. No partial shift is abandoned.
- Reset mid-operation: returns to the reset values immediately. No row_latch is emitted.

Optional Feature:
- BCM_SHIFT_WATCHDOG_EN defined:
  - A counter clears on entry to WAIT_SHIFT and increments each cycle there.
  - When the count reaches SHIFT_WATCHDOG without shift_done: shift_fault<=1 (sticky until reset), state→IDLE, brightness_mask_active<=0 (display blanks).
  - While shift_fault=1, IDLE ignores enable.
- Undefined: no counter; WAIT_SHIFT waits indefinitely; shift_fault is constant 0.

Test Plan:
- Reset sequence (BRIGHTNESS_LEVELS=3, ROWS=4): hold reset, enable=1 → all outputs at reset values, brightness_mask=3'b001; after release, shift_start pulses on cycle 2.
- Steady scan: shift_done 2 cycles after each shift_start, output_enable low → latches at mask 001,010,100 for row 0, then 001 for row 1. row_address_active follows. frame_start only at row 0/plane 001.
- On-time dominance: hold output_enable high 20 cycles after each latch, shift_done fast → row_latch rises exactly 1 cycle after output_enable falls; shift_start precedes it.
- Row wrap: run 12 latches → row_address_active sequence 0,0,0,1,1,1,2,2,2,3,3,3, then 0 with frame_start=1.
- Disable mid-plane: drop enable during WAIT_SHIFT → one more row_latch, then IDLE with brightness_mask_active=0 and no further shift_start.
- Watchdog (BCM_SHIFT_WATCHDOG_EN, SHIFT_WATCHDOG=8): withhold shift_done → shift_fault=1 after 8 cycles in WAIT_SHIFT, IDLE, no latch, and shift_fault persists until reset.

Source files
------------

// File: rtl/bcm_plane_scheduler.sv
// bcm_plane_scheduler
//   Binary-coded-modulation plane/row sequencer for the LED matrix. Requests a
//   shift of the next (row, plane) while the current plane is on. It latches the
//   new plane once the shifter reports done and the on-time has ended.
//
//   Optional feature macro: BCM_SHIFT_WATCHDOG_EN
//     defined   -> the WAIT_SHIFT watchdog is built. shift_fault is sticky until
//                  reset, and while it is set the scheduler stays in IDLE.
//     undefined -> WAIT_SHIFT waits forever. shift_fault is tied to 0.
//
//   Ports
//     clk_in                  system clock
//     reset                   asynchronous active-high reset
//     enable                  run request
//     shift_done              one-cycle pulse: requested plane fully shifted
//     output_enable           high while the current plane's on-time runs
//     shift_start             one-cycle shift request for (row_address, brightness_mask)
//     brightness_mask         one-hot plane being shifted
//     row_address             row being shifted
//     brightness_mask_active  one-hot plane being displayed (0 when idle)
//     row_address_active      row being displayed
//     row_latch               one-cycle latch strobe
//     frame_start             pulse with the latch of row 0, plane 0
//     shift_fault             sticky shift watchdog fault

package params_pkg;
  localparam int BRIGHTNESS_LEVELS = 8;
endpackage

module bcm_plane_scheduler #(
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int ROWS              = 16,
  parameter int SHIFT_WATCHDOG    = 4096
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         shift_done,
  input  logic                         output_enable,
  output logic                         shift_start,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_mask,
  output logic [$clog2(ROWS)-1:0]      row_address,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active,
  output logic [$clog2(ROWS)-1:0]      row_address_active,
  output logic                         row_latch,
  output logic                         frame_start,
  output logic                         shift_fault
);

  localparam int                         RA_W     = $clog2(ROWS);
  localparam logic [RA_W-1:0]            ROW_LAST = RA_W'(ROWS - 1);
  localparam logic [BRIGHTNESS_LEVELS-1:0] PLANE0 = BRIGHTNESS_LEVELS'(1);

  // Elaboration-time parameter sanity checks.
  if (BRIGHTNESS_LEVELS < 2) begin : g_bl_chk
    $error("BRIGHTNESS_LEVELS must be >= 2");
  end
  if (ROWS < 2) begin : g_rows_chk
    $error("ROWS must be >= 2");
  end
  if (SHIFT_WATCHDOG < 1) begin : g_wd_chk
    $error("SHIFT_WATCHDOG must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, SHIFT, WAIT_SHIFT, WAIT_OE, LATCH, ADVANCE
  } state_t;

  state_t state;
  logic   run_ok;

`ifdef BCM_SHIFT_WATCHDOG_EN
  localparam int              WD_W    = $clog2(SHIFT_WATCHDOG + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(SHIFT_WATCHDOG - 1);
  logic [WD_W-1:0] wd_cnt;
  // A faulted scheduler stays parked until reset.
  assign run_ok = enable & ~shift_fault;
`else
  assign run_ok      = enable;
  assign shift_fault = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      brightness_mask        <= PLANE0;
      row_address            <= '0;
      brightness_mask_active <= '0;
      row_address_active     <= '0;
      shift_start            <= 1'b0;
      row_latch              <= 1'b0;
      frame_start            <= 1'b0;
`ifdef BCM_SHIFT_WATCHDOG_EN
      wd_cnt                 <= '0;
      shift_fault            <= 1'b0;
`endif
    end else begin
      // The strobes are pulses. They are set on entry into their state and
      // cleared on every other cycle.
      shift_start <= 1'b0;
      row_latch   <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          // The zero mask reads as non-one-hot downstream, which blanks the display.
          brightness_mask_active <= '0;
          if (run_ok) begin
            state       <= SHIFT;
            shift_start <= 1'b1;
          end
        end
        SHIFT: begin
          // The shifter never answers in the request cycle, so shift_done is
          // not looked at here.
          state <= WAIT_SHIFT;
`ifdef BCM_SHIFT_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        WAIT_SHIFT: begin
          if (shift_done) begin
            state <= WAIT_OE;
`ifdef BCM_SHIFT_WATCHDOG_EN
          end else if (wd_cnt == WD_LAST) begin
            shift_fault            <= 1'b1;
            brightness_mask_active <= '0;
            state                  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        WAIT_OE: begin
          // Latch as soon as the previous plane's on-time has ended. The low
          // output_enable seen right after a latch is never sampled here,
          // because at least three states lie in between.
          if (!output_enable) begin
            state                  <= LATCH;
            row_latch              <= 1'b1;
            frame_start            <= (brightness_mask == PLANE0) && (row_address == '0);
            brightness_mask_active <= brightness_mask;
            row_address_active     <= row_address;
          end
        end
        LATCH: state <= ADVANCE;
        ADVANCE: begin
          brightness_mask <= {brightness_mask[BRIGHTNESS_LEVELS-2:0],
                              brightness_mask[BRIGHTNESS_LEVELS-1]};
          if (brightness_mask[BRIGHTNESS_LEVELS-1])
            row_address <= (row_address == ROW_LAST) ? '0 : row_address + 1'b1;
          if (run_ok) begin
            state       <= SHIFT;
            shift_start <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcm_plane_scheduler.sv
// Self-checking bench for bcm_plane_scheduler (BRIGHTNESS_LEVELS=3, ROWS=4,
// SHIFT_WATCHDOG=8). A shifter responder pushes the expected latch result each
// time it answers a shift request. A latch monitor pops and compares the result.
module tb_bcm_plane_scheduler;

  localparam int BL = 3;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          reset, enable, shift_done, output_enable;
  logic          shift_start, row_latch, frame_start, shift_fault;
  logic [BL-1:0] brightness_mask, brightness_mask_active;
  logic [1:0]    row_address, row_address_active;

  bcm_plane_scheduler #(.BRIGHTNESS_LEVELS(BL), .ROWS(RW), .SHIFT_WATCHDOG(8)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .shift_done(shift_done),
    .output_enable(output_enable), .shift_start(shift_start),
    .brightness_mask(brightness_mask), .row_address(row_address),
    .brightness_mask_active(brightness_mask_active),
    .row_address_active(row_address_active), .row_latch(row_latch),
    .frame_start(frame_start), .shift_fault(shift_fault)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [BL-1:0] mask;
    logic [1:0]    row;
    logic          frame;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   m_plane = 0, m_row = 0;
  int   shift_delay = 1, oe_hold = 0;
  bit   withhold = 0, chk_on_time = 0, oe_fall_valid = 0, shift_seen = 0;
  int   oe_fall_cyc = 0, latch_cnt = 0, ss_cnt = 0;
  int   hist_row[64];
  bit   hist_frame[64];

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [BL-1:0] model_mask();
    logic [BL-1:0] one;
    one = BL'(1);
    return one << m_plane;
  endfunction

  // Shifter model: checks the request, answers after shift_delay cycles and
  // records what the resulting latch must show.
  initial begin
    exp_t e;
    shift_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (shift_start && !reset) begin
        ss_cnt++;
        shift_seen = 1;
        tests++;
        if (brightness_mask !== model_mask() || row_address !== 2'(m_row)) begin
          fails++;
          $display("FAIL shift_req: mask=%b row=%0d, want mask=%b row=%0d",
                   brightness_mask, row_address, model_mask(), m_row);
        end
        if (!withhold) begin
          repeat (shift_delay) @(negedge clk_in);
          shift_done = 1'b1;
          e.mask  = model_mask();
          e.row   = 2'(m_row);
          e.frame = (m_plane == 0) && (m_row == 0);
          sb.push_back(e);
          m_plane++;
          if (m_plane == BL) begin
            m_plane = 0;
            m_row   = (m_row + 1) % RW;
          end
          @(negedge clk_in);
          shift_done = 1'b0;
        end
      end
    end
  end

  // On-time model: output_enable goes high the cycle after each latch and
  // stays high for oe_hold cycles.
  initial begin
    output_enable = 1'b0;
    forever begin
      @(negedge clk_in);
      if (row_latch && !reset && oe_hold > 0) begin
        @(negedge clk_in);
        output_enable = 1'b1;
        repeat (oe_hold) @(negedge clk_in);
        output_enable = 1'b0;
        oe_fall_cyc   = cyc;
        oe_fall_valid = 1;
      end
    end
  end

  // Latch monitor and scoreboard checker.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (row_latch && !reset) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL latch_unexpected: latch #%0d with empty scoreboard", latch_cnt);
          e.mask = 'x; e.row = 'x; e.frame = 1'b0;
        end else begin
          e = sb.pop_front();
        end
        tests++;
        if (frame_start !== e.frame) begin
          fails++;
          $display("FAIL frame_start: got %b want %b (latch #%0d)", frame_start, e.frame, latch_cnt);
        end
        if (chk_on_time) begin
          tests++;
          if (!shift_seen) begin
            fails++;
            $display("FAIL shift_before_latch: got no shift_start, want one before latch #%0d", latch_cnt);
          end
          if (oe_fall_valid) begin
            tests++;
            if (cyc !== oe_fall_cyc + 1) begin
              fails++;
              $display("FAIL latch_after_oe: latch cycle %0d, want %0d", cyc, oe_fall_cyc + 1);
            end
          end
        end
        oe_fall_valid = 0;
        shift_seen    = 0;
        if (latch_cnt < 64) hist_frame[latch_cnt] = frame_start;
        @(negedge clk_in);
        tests++;
        if (brightness_mask_active !== e.mask || row_address_active !== e.row) begin
          fails++;
          $display("FAIL active: mask=%b row=%0d, want mask=%b row=%0d",
                   brightness_mask_active, row_address_active, e.mask, e.row);
        end
        if (latch_cnt < 64) hist_row[latch_cnt] = int'(row_address_active);
        latch_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    withhold = 0;
    chk_on_time = 0;
    repeat (3) @(negedge clk_in);
    sb.delete();
    m_plane = 0; m_row = 0;
    latch_cnt = 0; ss_cnt = 0;
    oe_fall_valid = 0; shift_seen = 0;
    reset = 1'b0;
  endtask

  task automatic wait_latches(input int target, input int budget, input string name);
    int n = 0;
    while (latch_cnt < target && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    tests++;
    if (latch_cnt < target) begin
      fails++;
      $display("FAIL %s_timeout: got %0d latches, want %0d", name, latch_cnt, target);
    end
  endtask

  task automatic wait_shift_start(input string name);
    int n = 0;
    while (!shift_start && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    tests++;
    if (!shift_start) begin
      fails++;
      $display("FAIL %s_no_shift: got shift_start=0, want 1", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; shift_delay = 1; oe_hold = 0;
    repeat (3) @(negedge clk_in);
    tests++;
    if (brightness_mask !== 3'b001 || row_address !== 2'd0) begin
      fails++;
      $display("FAIL reset_shift_regs: mask=%b row=%0d, want 001/0", brightness_mask, row_address);
    end
    tests++;
    if (brightness_mask_active !== 3'b000 || row_address_active !== 2'd0) begin
      fails++;
      $display("FAIL reset_active: mask=%b row=%0d, want 000/0", brightness_mask_active, row_address_active);
    end
    tests++;
    if ({shift_start, row_latch, frame_start, shift_fault} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_strobes: got %b want 0000", {shift_start, row_latch, frame_start, shift_fault});
    end
    sb.delete(); m_plane = 0; m_row = 0; latch_cnt = 0; ss_cnt = 0;
    reset = 1'b0;
    tests++;
    if (shift_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_c1: shift_start=%b want 0", shift_start);
    end
    @(negedge clk_in);
    tests++;
    if (shift_start !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_c2: shift_start=%b want 1", shift_start);
    end
    @(negedge clk_in);
    tests++;
    if (shift_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_c3: shift_start=%b want 0", shift_start);
    end
    enable = 1'b0;
    repeat (40) @(negedge clk_in);
  endtask

  task automatic test_steady();
    do_reset();
    shift_delay = 2; oe_hold = 0;
    enable = 1'b1;
    wait_latches(4, 200, "steady");
    enable = 1'b0;
    repeat (40) @(negedge clk_in);
    tests++;
    if (hist_row[0] !== 0 || hist_row[2] !== 0 || hist_row[3] !== 1) begin
      fails++;
      $display("FAIL steady_rows: got %0d,%0d,%0d want 0,0,1", hist_row[0], hist_row[2], hist_row[3]);
    end
  endtask

  task automatic test_min_period();
    int c0;
    do_reset();
    shift_delay = 1; oe_hold = 0;
    enable = 1'b1;
    wait_latches(1, 100, "minper1");
    c0 = cyc;
    wait_latches(2, 100, "minper2");
    tests++;
    if (cyc - c0 !== 5) begin
      fails++;
      $display("FAIL min_period: got %0d cycles want 5", cyc - c0);
    end
    enable = 1'b0;
    repeat (40) @(negedge clk_in);
  endtask

  task automatic test_on_time();
    do_reset();
    shift_delay = 1; oe_hold = 20;
    chk_on_time = 1;
    enable = 1'b1;
    wait_latches(4, 400, "on_time");
    enable = 1'b0;
    repeat (60) @(negedge clk_in);
    chk_on_time = 0;
    oe_hold = 0;
  endtask

  task automatic test_row_wrap();
    int want[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    do_reset();
    shift_delay = 1; oe_hold = 0;
    enable = 1'b1;
    wait_latches(13, 300, "row_wrap");
    repeat (2) @(negedge clk_in);
    enable = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tests++;
      if (hist_row[i] !== want[i]) begin
        fails++;
        $display("FAIL row_wrap_seq[%0d]: got %0d want %0d", i, hist_row[i], want[i]);
      end
    end
    tests++;
    if (hist_frame[12] !== 1'b1 || hist_frame[3] !== 1'b0) begin
      fails++;
      $display("FAIL row_wrap_frame: got %b/%b want 1/0", hist_frame[12], hist_frame[3]);
    end
    repeat (40) @(negedge clk_in);
  endtask

  task automatic test_disable();
    int l0, s0;
    do_reset();
    shift_delay = 4; oe_hold = 0;
    enable = 1'b1;
    wait_latches(2, 100, "disable");
    wait_shift_start("disable");
    @(negedge clk_in);
    enable = 1'b0;  // dropped while in WAIT_SHIFT
    l0 = latch_cnt; s0 = ss_cnt;
    repeat (40) @(negedge clk_in);
    tests++;
    if (latch_cnt !== l0 + 1) begin
      fails++;
      $display("FAIL disable_latches: got %0d want %0d", latch_cnt, l0 + 1);
    end
    tests++;
    if (ss_cnt !== s0) begin
      fails++;
      $display("FAIL disable_shift: got %0d shift_starts want %0d", ss_cnt, s0);
    end
    tests++;
    if (brightness_mask_active !== 3'b000) begin
      fails++;
      $display("FAIL disable_blank: got %b want 000", brightness_mask_active);
    end
  endtask

  task automatic test_watchdog();
    int n = 0, s0;
    do_reset();
    withhold = 1;
    enable = 1'b1;
    wait_shift_start("watchdog");
`ifdef BCM_SHIFT_WATCHDOG_EN
    while (!shift_fault && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    tests++;
    if (n !== 9) begin
      fails++;
      $display("FAIL wd_latency: fault after %0d cycles want 9", n);
    end
    s0 = ss_cnt;
    repeat (20) @(negedge clk_in);
    tests++;
    if (shift_fault !== 1'b1 || latch_cnt !== 0 || ss_cnt !== s0) begin
      fails++;
      $display("FAIL wd_sticky: fault=%b latches=%0d shifts=%0d want 1/0/%0d",
               shift_fault, latch_cnt, ss_cnt, s0);
    end
    tests++;
    if (brightness_mask_active !== 3'b000) begin
      fails++;
      $display("FAIL wd_blank: got %b want 000", brightness_mask_active);
    end
`else
    s0 = ss_cnt;
    repeat (50) @(negedge clk_in);
    n = latch_cnt;
    tests++;
    if (shift_fault !== 1'b0 || n !== 0 || ss_cnt !== s0) begin
      fails++;
      $display("FAIL no_wd_wait: fault=%b latches=%0d shifts=%0d want 0/0/%0d",
               shift_fault, n, ss_cnt, s0);
    end
`endif
    do_reset();
    tests++;
    if (shift_fault !== 1'b0) begin
      fails++;
      $display("FAIL wd_reset_clear: got %b want 0", shift_fault);
    end
    repeat (5) @(negedge clk_in);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    test_reset();
    test_steady();
    test_min_period();
    test_on_time();
    test_row_wrap();
    test_disable();
    test_watchdog();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
